// File: rtl/seg_pkg.sv
// Seven-segment constants and the BCD decode shared by the display scanner.
// Patterns are active-high, bit0=a .. bit6=g.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  // Codes 10..15 fall through to a dash so bad counter data is visible.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] bcd);
    logic [SEG_W-1:0] s;
    s = SEG_DASH;
    for (int k = 0; k < 10; k++)
      if (bcd == 4'(k)) s = SEG_LUT[k];
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD to seven-segment decoder (active-high gfedcba).
module seven_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 5-digit seven-segment scanner with per-frame snapshot,
// leading-zero blanking and a dead-time gap at the start of each digit slot.
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS         = 5,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD           = 4,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        digit0,
  input  logic [3:0]        digit1,
  input  logic [3:0]        digit2,
  input  logic [3:0]        digit3,
  input  logic [3:0]        digit4,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              frame_tick
);

  localparam int IN_DIGITS = 5;
  localparam int CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SEG_W-1:0]  SEG_OFF_LVL = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] AN_OFF_LVL  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [IN_DIGITS-1:0][3:0] din;
  logic [DIGITS-1:0][3:0]    din_ext;
  logic [DIGITS-1:0][3:0]    shadow;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic                      reload_pend;
  logic                      slot_end, frame_end, load;

  logic [DIGITS-1:0]         blank;
  logic                      zero_run;
  logic [3:0]                cur_bcd;
  logic                      cur_blank;
  logic [SEG_W-1:0]          cur_seg;
  logic                      lit;
  logic [SEG_W-1:0]          seg_nxt;
  logic [DIGITS-1:0]         an_nxt;

  assign din = {digit4, digit3, digit2, digit1, digit0};

  // Positions beyond the physical inputs read as zero.
  for (genvar g = 0; g < DIGITS; g++) begin : g_din
    if (g < IN_DIGITS) begin : g_in
      assign din_ext[g] = din[g];
    end else begin : g_zero
      assign din_ext[g] = 4'd0;
    end
  end

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
  // A coincident frame end and post-reset reload collapse into one load.
  assign load      = frame_end || reload_pend;

  // A digit is blank when it and every more-significant digit is zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow[k] == 4'd0);
      blank[k] = (BLANK_LEADING != 0) && zero_run;
    end
  end

  always_comb begin
    cur_bcd   = 4'd0;
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_bcd   = shadow[k];
        cur_blank = blank[k];
      end
    end
  end

  seven_seg_decoder u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // Segments stay dark through the dead gap as well, so no ghost of the
  // new digit appears while the anodes switch over.
  assign lit     = (cnt >= CNT_W'(DEAD)) && !cur_blank;
  assign seg_nxt = lit ? cur_seg : SEG_OFF;

  always_comb begin
    an_nxt = '0;
    for (int k = 0; k < DIGITS; k++)
      an_nxt[k] = lit && (idx == IDX_W'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      reload_pend <= 1'b1;
      frame_tick  <= 1'b0;
      seg         <= SEG_OFF_LVL;
      an          <= AN_OFF_LVL;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end)
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      if (load)
        shadow <= din_ext;
      reload_pend <= 1'b0;
      frame_tick  <= load;
      seg         <= (SEG_ACTIVE_LOW != 0) ? ~seg_nxt : seg_nxt;
      an          <= (AN_ACTIVE_LOW != 0) ? ~an_nxt : an_nxt;
    end
  end

  assign dp = (SEG_ACTIVE_LOW != 0);

endmodule
